// File: rtl/linear_layer_start_fifo_arb_ctrl.sv
// Two-requester arbitrated write front end for a show-ahead FIFO built on an
// external shift-register store; tracks occupancy, read index and a sticky error.
module linear_layer_start_fifo_arb_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr0_din,
    input  logic                  wr0_write,
    output logic                  wr0_full_n,
    input  logic [DATA_WIDTH-1:0] wr1_din,
    input  logic                  wr1_write,
    output logic                  wr1_full_n,
    output logic [DATA_WIDTH-1:0] rd_dout,
    output logic                  rd_empty_n,
    input  logic                  rd_read,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0]   count_q, count_d, count_m1;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  prio_q, prio_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  err_q, err_d;
    logic                  grant0, grant1, acc_w, acc_r, wr_viol;

    always_comb begin
        grant0     = wr0_write & (~wr1_write | ~prio_q);
        grant1     = wr1_write & (~wr0_write |  prio_q);
        // A requester is held off while full, or while the other one owns priority and is writing.
        wr0_full_n = full_n_q & ~(wr1_write &  prio_q);
        wr1_full_n = full_n_q & ~(wr0_write & ~prio_q);
        acc_w      = full_n_q & (grant0 | grant1);
        acc_r      = rd_read & empty_n_q;

        srl_we     = acc_w & ~reset;
        srl_din    = grant1 ? wr1_din : wr0_din;
        rd_dout    = srl_dout;

        count_d = count_q;
        if (acc_w && !acc_r)      count_d = count_q + 1'b1;
        else if (acc_r && !acc_w) count_d = count_q - 1'b1;
        count_m1 = count_d - 1'b1;

        // The oldest token lives at count-1; a balanced push/pop leaves it in place.
        addr_d = addr_q;
        if (!(acc_w && acc_r)) addr_d = (count_d != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;

        prio_d    = acc_w ? grant0 : prio_q;
        full_n_d  = count_d < DEPTH_C;
        empty_n_d = count_d != '0;

        // Losing arbitration is not a fault; pushing into a full store is, unless a pop drains it that cycle.
        wr_viol = (wr0_write & ~wr0_full_n & ~grant1) | (wr1_write & ~wr1_full_n & ~grant0);
        err_d   = err_q | (rd_read & ~empty_n_q) | (wr_viol & ~acc_r);
    end

    // NOTE: state registers use non-blocking assignment; the token store itself is external and never reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            addr_q    <= '0;
            prio_q    <= 1'b0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            addr_q    <= addr_d;
            prio_q    <= prio_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            err_q     <= err_d;
        end
    end

    assign count      = count_q;
    assign srl_addr   = addr_q;
    assign rd_empty_n = empty_n_q;
    assign err        = err_q;

endmodule

// File: tb/tb_linear_layer_start_fifo_arb_ctrl.sv
// Randomised and directed bench for linear_layer_start_fifo_arb_ctrl against a
// token-queue reference model, with a behavioural shift-register store attached.
module tb_linear_layer_start_fifo_arb_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] wr0_din, wr1_din;
    logic          wr0_write, wr1_write, rd_read;
    logic          wr0_full_n, wr1_full_n, rd_empty_n, srl_we, err;
    logic [DW-1:0] rd_dout, srl_din, srl_dout;
    logic [AW-1:0] srl_addr;
    logic [AW:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: oldest token at the front
    logic [DW-1:0] q[$];
    bit            m_prio;
    bit            m_err;

    logic [DW-1:0] srl_mem[DEPTH];

    linear_layer_start_fifo_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr0_din(wr0_din), .wr0_write(wr0_write), .wr0_full_n(wr0_full_n),
        .wr1_din(wr1_din), .wr1_write(wr1_write), .wr1_full_n(wr1_full_n),
        .rd_dout(rd_dout), .rd_empty_n(rd_empty_n), .rd_read(rd_read),
        .srl_we(srl_we), .srl_addr(srl_addr), .srl_din(srl_din), .srl_dout(srl_dout),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = DEPTH - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= srl_din;
        end
    end
    assign srl_dout = srl_mem[srl_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input bit w0, input logic [DW-1:0] d0, input bit w1,
                              input logic [DW-1:0] d1, input bit rd);
        wr0_write = w0; wr0_din = d0; wr1_write = w1; wr1_din = d1; rd_read = rd;
    endtask

    // One clock of stimulus; combinational outputs compared before the edge, state after it.
    task automatic cycle(input bit w0, input logic [DW-1:0] d0, input bit w1,
                         input logic [DW-1:0] d1, input bit rd,
                         output logic [DW-1:0] din_seen, output logic [DW-1:0] dout_seen);
        bit full, empty, g0, g1, f0, f1, accw, accr, viol;
        int sz;
        set_inputs(w0, d0, w1, d1, rd);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        g0    = w0 && (!w1 || !m_prio);
        g1    = w1 && (!w0 || m_prio);
        f0    = !full && !(w1 && m_prio);
        f1    = !full && !(w0 && !m_prio);
        accw  = !full && (g0 || g1);
        accr  = rd && !empty;
        viol  = (w0 && !f0 && !g1) || (w1 && !f1 && !g0);
        #1;
        n_tests++;
        if (wr0_full_n !== f0) begin n_fail++; $display("FAIL wr0_full_n: got %b expected %b", wr0_full_n, f0); end
        n_tests++;
        if (wr1_full_n !== f1) begin n_fail++; $display("FAIL wr1_full_n: got %b expected %b", wr1_full_n, f1); end
        n_tests++;
        if (srl_we !== accw) begin n_fail++; $display("FAIL srl_we: got %b expected %b", srl_we, accw); end
        if (accw) begin
            n_tests++;
            if (srl_din !== (g1 ? d1 : d0)) begin
                n_fail++; $display("FAIL srl_din: got %h expected %h", srl_din, g1 ? d1 : d0);
            end
        end
        if (!empty) begin
            n_tests++;
            if (rd_dout !== q[0]) begin n_fail++; $display("FAIL rd_dout: got %h expected %h", rd_dout, q[0]); end
        end
        din_seen  = srl_din;
        dout_seen = rd_dout;
        @(posedge clk);
        if (rd && empty) m_err = 1'b1;
        if (viol && !accr) m_err = 1'b1;
        if (accr) void'(q.pop_front());
        if (accw) begin
            q.push_back(g1 ? d1 : d0);
            m_prio = g0;
        end
        #1;
        sz = q.size();
        n_tests++;
        if (count !== (AW+1)'(sz)) begin n_fail++; $display("FAIL count: got %0d expected %0d", count, sz); end
        n_tests++;
        if (srl_addr !== ((sz > 0) ? AW'(sz - 1) : AW'(0))) begin
            n_fail++; $display("FAIL srl_addr: got %0d expected %0d", srl_addr, (sz > 0) ? sz - 1 : 0);
        end
        n_tests++;
        if (rd_empty_n !== (sz != 0)) begin n_fail++; $display("FAIL rd_empty_n: got %b expected %b", rd_empty_n, sz != 0); end
        n_tests++;
        if (err !== m_err) begin n_fail++; $display("FAIL err: got %b expected %b", err, m_err); end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        set_inputs(0, '0, 0, '0, 0);
        #2 reset = 1'b0;
        q.delete();
        m_prio = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] a, b;
        reset = 1'b1;
        set_inputs(1, 4'h1, 1, 4'h2, 1);
        #2;
        n_tests++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++;
        if (srl_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", srl_addr); end
        n_tests++;
        if (rd_empty_n !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got empty_n=%b err=%b expected 0 0", rd_empty_n, err);
        end
        n_tests++;
        if (srl_we !== 1'b0 || wr0_full_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_we: got srl_we=%b wr0_full_n=%b expected 0 1", srl_we, wr0_full_n);
        end
        set_inputs(0, '0, 0, '0, 0);
        #1 reset = 1'b0;
        q.delete(); m_prio = 1'b0; m_err = 1'b0;
        // first edge after release must already accept a write
        cycle(1, 4'h9, 0, '0, 0, a, b);
        n_tests++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL first_write: got count %0d expected 1", count); end
    endtask

    task automatic test_single_writer();
        logic [DW-1:0] a, b;
        logic [DW-1:0] toks[4];
        toks = '{4'hA, 4'hB, 4'hC, 4'hD};
        apply_reset();
        foreach (toks[i]) cycle(1, toks[i], 0, '0, 0, a, b);
        n_tests++;
        if (count !== 3'd4 || wr0_full_n !== 1'b0) begin
            n_fail++; $display("FAIL sw_full: got count %0d full_n %b expected 4 0", count, wr0_full_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (srl_addr !== 2'(3 - i)) begin n_fail++; $display("FAIL sw_addr: got %0d expected %0d", srl_addr, 3 - i); end
            cycle(0, '0, 0, '0, 1, a, b);
            n_tests++;
            if (b !== toks[i]) begin n_fail++; $display("FAIL sw_read: got %h expected %h", b, toks[i]); end
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] a, b;
        logic [DW-1:0] order[4];
        order = '{4'h1, 4'h2, 4'h1, 4'h2};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4'h1, 1, 4'h2, 0, a, b);
            n_tests++;
            if (a !== order[i]) begin n_fail++; $display("FAIL contention_grant%0d: got %h expected %h", i, a, order[i]); end
        end
        set_inputs(0, '0, 0, '0, 0);
        n_tests++;
        if (count !== 3'd4 || err !== 1'b0) begin
            n_fail++; $display("FAIL contention_end: got count %0d err %b expected 4 0", count, err);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] a, b;
        apply_reset();
        cycle(1, 4'h3, 0, '0, 0, a, b);
        cycle(1, 4'h7, 0, '0, 0, a, b);
        cycle(1, 4'h5, 0, '0, 1, a, b);
        n_tests++;
        if (b !== 4'h3) begin n_fail++; $display("FAIL simul_pop: got %h expected 3", b); end
        n_tests++;
        if (count !== 3'd2 || srl_addr !== 2'd1 || rd_dout !== 4'h7) begin
            n_fail++; $display("FAIL simul_state: got count %0d addr %0d dout %h expected 2 1 7", count, srl_addr, rd_dout);
        end
        cycle(0, '0, 0, '0, 1, a, b);
        cycle(0, '0, 0, '0, 1, a, b);
        n_tests++;
        if (b !== 4'h5) begin n_fail++; $display("FAIL simul_tail: got %h expected 5", b); end
    endtask

    task automatic test_full_read();
        logic [DW-1:0] a, b;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1, 4'(i + 4), 0, '0, 0, a, b);
        cycle(0, '0, 1, 4'hE, 1, a, b);
        n_tests++;
        if (count !== 3'd3 || err !== 1'b0) begin
            n_fail++; $display("FAIL full_read: got count %0d err %b expected 3 0", count, err);
        end
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, 1, a, b);
    endtask

    task automatic test_violation();
        logic [DW-1:0] a, b;
        apply_reset();
        cycle(0, '0, 0, '0, 1, a, b);
        n_tests++;
        if (err !== 1'b1 || count !== 3'd0) begin
            n_fail++; $display("FAIL viol_empty: got err %b count %0d expected 1 0", err, count);
        end
        for (int i = 0; i < 3; i++) cycle(1, 4'(i), 0, '0, 1, a, b);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL viol_sticky: got %b expected 1", err); end
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 4'(i), 0, a, b);
        n_tests++;
        if (err !== 1'b1 || count !== 3'd4) begin
            n_fail++; $display("FAIL viol_full: got err %b count %0d expected 1 4", err, count);
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] a, b;
        apply_reset();
        cycle(1, 4'h1, 0, '0, 0, a, b);
        cycle(0, '0, 1, 4'h2, 0, a, b);
        cycle(1, 4'h3, 0, '0, 0, a, b);
        set_inputs(1, 4'h6, 0, '0, 0);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (count !== 3'd0 || rd_empty_n !== 1'b0 || wr0_full_n !== 1'b1 || srl_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got count %0d empty_n %b full_n %b we %b expected 0 0 1 0",
                     count, rd_empty_n, wr0_full_n, srl_we);
        end
        #2 reset = 1'b0;
        q.delete(); m_prio = 1'b0; m_err = 1'b0;
        cycle(1, 4'hA, 1, 4'hB, 0, a, b);
        n_tests++;
        if (a !== 4'hA) begin n_fail++; $display("FAIL mid_reset_prio: got %h expected A", a); end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                  1'($urandom_range(0, 2) != 0), a, b);
        end
    endtask

    initial begin
        set_inputs(0, '0, 0, '0, 0);
        test_reset();
        test_single_writer();
        test_contention();
        test_simultaneous();
        test_full_read();
        test_violation();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_layer_start_fifo_arb_ctrl.md
LINEAR_LAYER_START_FIFO_ARB_CTRL -- requirements
Module: linear_layer_start_fifo_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1, meaning token width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, meaning width of the storage read address.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning number of storage entries (2 <= DEPTH <= 2**ADDR_WIDTH).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have ports wr0_din and wr1_din, input, DATA_WIDTH, meaning requester 0/1 write data.
REQ-007 The block SHALL have ports wr0_write and wr1_write, input, 1, meaning requester 0/1 write request.
REQ-008 The block SHALL have ports wr0_full_n and wr1_full_n, output, 1, meaning requester 0/1 may write this cycle.
REQ-009 The block SHALL have port rd_dout, output, DATA_WIDTH, meaning oldest stored token (show-ahead).
REQ-010 The block SHALL have port rd_empty_n, output, 1, meaning at least one token is stored.
REQ-011 The block SHALL have port rd_read, input, 1, meaning consumer pops rd_dout this cycle.
REQ-012 The block SHALL have port srl_we, output, 1, meaning shift-in enable to the external shift-register storage.
REQ-013 The block SHALL have port srl_addr, output, ADDR_WIDTH, meaning storage read index.
REQ-014 The block SHALL have port srl_din, output, DATA_WIDTH, meaning token shifted into storage index 0.
REQ-015 The block SHALL have port srl_dout, input, DATA_WIDTH, meaning storage entry at srl_addr (combinational).
REQ-016 The block SHALL have port count, output, ADDR_WIDTH+1, meaning stored token count.
REQ-017 The block SHALL have port err, output, 1, meaning sticky protocol-violation flag.

Function
REQ-018 Storage model: write shifts entry i to i+1 and puts srl_din at 0; oldest token sits at index count-1.
REQ-019 full_n SHALL be registered, equal to (count < DEPTH); rd_empty_n SHALL be registered, equal to (count != 0).
REQ-020 Arbitration SHALL use a 1-bit registered priority pointer prio (0 favours wr0, 1 favours wr1).
REQ-021 grant0 = wr0_write & (~wr1_write | prio==0); grant1 = wr1_write & (~wr0_write | prio==1); never both.
REQ-022 wrK_full_n = full_n & ~(wrJ_write & prio==J), J the other requester; combinational from wrJ_write only.
REQ-023 Write accepted (acc_w) = full_n & (grant0 | grant1); srl_we = acc_w; srl_din = granted requester's din (wr0_din when neither).
REQ-024 After an accepted write, prio SHALL point to the non-granted requester; otherwise prio holds.
REQ-025 Read accepted (acc_r) = rd_read & rd_empty_n; rd_dout = srl_dout combinationally, zero extra latency.
REQ-026 count update: acc_w only -> +1; acc_r only -> -1; both or neither -> unchanged.
REQ-027 srl_addr SHALL be registered: count_next-1 when count_next>0, else 0; unchanged on simultaneous acc_w & acc_r.
REQ-028 Write-to-read latency: token written at edge N SHALL be visible on rd_dout with rd_empty_n=1 after edge N.
REQ-029 With count==DEPTH, a write SHALL be refused even if rd_read is high the same cycle (no write-through on full).
REQ-030 With count==0, rd_read SHALL have no effect on state; no read-through of a same-cycle write.
REQ-031 err SHALL set on edge when (rd_read & ~rd_empty_n) or (any wrK_write & ~wrK_full_n & ~grant of other) is observed with wrK_write on full; clears only by reset.

Reset
REQ-032 While reset=1 (asynchronously): count=0, srl_addr=0, prio=0, full_n=1, rd_empty_n=0, err=0; srl_we=0 regardless of requests.
REQ-033 Storage contents SHALL NOT be reset; reset mid-operation discards all stored tokens.
REQ-034 First accepted transfer SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-035 Single writer: wr0 writes 0xA,0xB,0xC,0xD (DATA_WIDTH=4) -> count=4, wr0_full_n=0; reads return A,B,C,D, srl_addr 3,2,1,0.
REQ-036 Contention: wr0_write=wr1_write=1 continuous, no reads -> grants alternate wr0,wr1,wr0,wr1, count saturates at 4, err=0.
REQ-037 Simultaneous: count=2, write 0x5 and read same cycle -> count stays 2, srl_addr stays 1, next rd_dout is second-oldest.
REQ-038 Full plus read: count=4, wr1_write=1, rd_read=1 -> write refused, count=3 next, err=0.
REQ-039 Violations: rd_read=1 while empty -> err=1, count=0; err stays 1 until reset.
REQ-040 Reset mid-stream: count=3, assert reset between edges -> count=0, rd_empty_n=0, full_n=1 immediately, prio=0.
